// File: rtl/ras_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ras_pkg : shared types and constants for the ras sequencer       |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
package ras_pkg;

  localparam int unsigned RAS_WIDTH = 32;
  localparam int unsigned RAS_DEPTH = 1024;
  localparam int unsigned RAS_ADDR  = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPEC    = 2'd1,
    ST_RESOLVE = 2'd2
  } ras_state_e;

  typedef struct packed {
    logic                 push;
    logic                 pop;
    logic                 branch;
    logic                 hit;
    logic [RAS_WIDTH-1:0] addr;
  } ras_op_t;

  typedef struct packed {
    logic valid;
    logic hit;
    logic kill;
  } ras_pred_t;

  // Occupancy needs one extra bit so that a full stack (== DEPTH) is representable.
  function automatic int unsigned occ_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ras_occ_ckpt.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ras_occ_ckpt : saturating occupancy counter with checkpoint      |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
module ras_occ_ckpt import ras_pkg::*; #(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned ADDR  = RAS_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          restore,
  input  logic          ckpt_load,
  output logic [ADDR:0] base,
  output logic          overflow
);

  localparam int unsigned     OCC_W = occ_width(ADDR);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ONE  = OCC_W'(1);

  logic [OCC_W-1:0] count_q, count_d;
  logic [OCC_W-1:0] ckpt_q, ckpt_d;
  logic             overflow_q, overflow_d;

  // base is the count the current op applies to, already rolled back on restore
  always_comb begin
    base    = restore ? ckpt_q : count_q;
    count_d = base;
    if (inc && !dec && (base != FULL)) begin
      count_d = base + ONE;
    end else if (dec && !inc && (base != '0)) begin
      count_d = base - ONE;
    end
    ckpt_d     = ckpt_load ? count_d : ckpt_q;
    overflow_d = overflow_q | (inc && (base == FULL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      ckpt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      ckpt_q     <= ckpt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: rtl/ras_spec_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ras_spec_ctrl : fetch/resolve to ras strobe sequencer            |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
module ras_spec_ctrl import ras_pkg::*; #(
  parameter int unsigned WIDTH = RAS_WIDTH,
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned ADDR  = RAS_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic             f_call,
  input  logic             f_ret,
  input  logic             f_branch,
  input  logic [WIDTH-1:0] f_ret_addr,
  output logic             f_ready,
  output logic             f_br_ready,
  input  logic             res_valid,
  input  logic             res_mispredict,
  output logic             ret_pred_valid,
  output logic             ret_pred_hit,
  output logic [WIDTH-1:0] ret_pred_addr,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  output logic             overflow
);

  ras_state_e       state_q, state_d;
  logic             live_q;
  logic             push_q, pop_q, branch_q;
  logic             push_d, pop_d, branch_d;
  logic             close_valid_q, close_valid_d;
  logic             close_invalid_q, close_invalid_d;
  logic [WIDTH-1:0] din_q, din_d;
  ras_pred_t        s1_q, s1_d, s2_q, s2_d;

  ras_op_t          op;
  logic             in_spec, accept, restore, kill;
  logic [ADDR:0]    occ_base;

  always_comb begin
    in_spec    = (state_q == ST_SPEC);
    f_ready    = live_q && !(in_spec && res_valid);
    f_br_ready = live_q && !in_spec;
    accept     = f_valid && f_ready;
    restore    = (state_q == ST_RESOLVE) && close_invalid_q;
    kill       = in_spec && res_valid && res_mispredict;

    op        = '0;
    op.push   = accept && f_call;
    op.hit    = accept && f_ret && (occ_base != '0);
    op.pop    = op.hit;
    op.branch = accept && f_branch && !in_spec;
    op.addr   = op.push ? f_ret_addr : '0;

    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (op.branch) state_d = ST_SPEC;
      ST_SPEC:    if (res_valid) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = op.branch ? ST_SPEC : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    push_d          = op.push;
    pop_d           = op.pop;
    branch_d        = op.branch;
    din_d           = op.addr;
    close_valid_d   = in_spec && res_valid && !res_mispredict;
    close_invalid_d = kill;

    // Nothing is accepted in the mispredict cycle, so only the older entry can need killing.
    s1_d      = '{valid: accept && f_ret, hit: op.hit, kill: 1'b0};
    s2_d      = s1_q;
    s2_d.kill = s1_q.kill | kill;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      live_q          <= 1'b0;
      push_q          <= 1'b0;
      pop_q           <= 1'b0;
      branch_q        <= 1'b0;
      din_q           <= '0;
      close_valid_q   <= 1'b0;
      close_invalid_q <= 1'b0;
      s1_q            <= '0;
      s2_q            <= '0;
    end else begin
      state_q         <= state_d;
      live_q          <= 1'b1;
      push_q          <= push_d;
      pop_q           <= pop_d;
      branch_q        <= branch_d;
      din_q           <= din_d;
      close_valid_q   <= close_valid_d;
      close_invalid_q <= close_invalid_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
    end
  end

  ras_occ_ckpt #(
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .inc       (op.push),
    .dec       (op.pop),
    .restore   (restore),
    .ckpt_load (op.branch),
    .base      (occ_base),
    .overflow  (overflow)
  );

  assign ras_push          = push_q;
  assign ras_pop           = pop_q;
  assign ras_branch        = branch_q;
  assign ras_din           = din_q;
  assign ras_close_valid   = close_valid_q;
  assign ras_close_invalid = close_invalid_q;

  assign ret_pred_valid = s2_q.valid && !s2_q.kill;
  assign ret_pred_hit   = ret_pred_valid && s2_q.hit;
  assign ret_pred_addr  = ret_pred_hit ? ras_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_ras_spec_ctrl.sv
`default_nettype none
// tb_ras_spec_ctrl: scoreboard bench for ras_spec_ctrl with a behavioural ras model,
// plus a DEPTH=4 instance for saturation and mid-window reset.
module tb_ras_spec_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst, f_valid, f_call, f_ret, f_branch, res_valid, res_mispredict;
  logic [31:0] f_ret_addr;
  logic        f_ready, f_br_ready, ret_pred_valid, ret_pred_hit, overflow;
  logic [31:0] ret_pred_addr, ras_din;
  logic        ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [31:0] m_dout = '0;

  // small instance
  logic        rst2, g_valid, g_call, g_ret, g_branch, g_res_valid, g_res_mp;
  logic [31:0] g_ret_addr;
  logic        g_ready, g_br_ready, g_pred_valid, g_pred_hit, g_ovf;
  logic [31:0] g_pred_addr, g_din;
  logic        g_push, g_pop, g_br_o, g_cv, g_ci;
  logic [31:0] g_dout = '0;

  ras_spec_ctrl #(.WIDTH(32), .DEPTH(1024), .ADDR(10)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_call(f_call), .f_ret(f_ret),
    .f_branch(f_branch), .f_ret_addr(f_ret_addr), .f_ready(f_ready),
    .f_br_ready(f_br_ready), .res_valid(res_valid), .res_mispredict(res_mispredict),
    .ret_pred_valid(ret_pred_valid), .ret_pred_hit(ret_pred_hit),
    .ret_pred_addr(ret_pred_addr), .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_branch(ras_branch), .ras_close_valid(ras_close_valid),
    .ras_close_invalid(ras_close_invalid), .ras_din(ras_din), .ras_dout(m_dout),
    .overflow(overflow)
  );

  ras_spec_ctrl #(.WIDTH(32), .DEPTH(4), .ADDR(2)) dut2 (
    .clk(clk), .rst(rst2), .f_valid(g_valid), .f_call(g_call), .f_ret(g_ret),
    .f_branch(g_branch), .f_ret_addr(g_ret_addr), .f_ready(g_ready),
    .f_br_ready(g_br_ready), .res_valid(g_res_valid), .res_mispredict(g_res_mp),
    .ret_pred_valid(g_pred_valid), .ret_pred_hit(g_pred_hit),
    .ret_pred_addr(g_pred_addr), .ras_push(g_push), .ras_pop(g_pop),
    .ras_branch(g_br_o), .ras_close_valid(g_cv), .ras_close_invalid(g_ci),
    .ras_din(g_din), .ras_dout(g_dout), .overflow(g_ovf)
  );

  typedef struct {
    int          cyc;
    bit          push, pop, br, cv, ci;
    logic [31:0] din;
  } strobe_t;

  typedef struct {
    int          cyc;
    bit          hit;
    logic [31:0] addr;
  } pred_t;

  strobe_t sq[$];
  pred_t   pq[$];
  strobe_t se;
  pred_t   pe;
  int      checks = 0;
  int      errors = 0;
  int      cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ras: registered read data, single checkpoint for one window.
  int m_sp = 0;
  int m_saved = 0;
  logic [31:0] m_stack [0:15];
  always @(posedge clk) begin : ras_model
    int nsp;
    nsp = m_sp;
    if (ras_close_invalid) nsp = m_saved;
    if (ras_push && ras_pop) begin
      m_dout <= m_stack[nsp-1];
      m_stack[nsp-1] <= ras_din;
    end else if (ras_push) begin
      m_stack[nsp] <= ras_din;
      nsp = nsp + 1;
    end else if (ras_pop) begin
      m_dout <= m_stack[nsp-1];
      nsp = nsp - 1;
    end
    if (ras_branch) m_saved <= nsp;
    m_sp <= nsp;
  end

  // Monitor: compares every presented strobe/prediction against the queued expectation.
  always @(negedge clk) begin
    if (ras_push || ras_pop || ras_branch || ras_close_valid || ras_close_invalid) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: got push=%0b pop=%0b br=%0b cv=%0b ci=%0b at cycle %0d, expected none",
                 ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid, cyc);
      end else begin
        se = sq.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(se.cyc));
        chk("strobe_flags", {27'd0, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid},
            {27'd0, se.push, se.pop, se.br, se.cv, se.ci});
        if (se.push) chk("ras_din", ras_din, se.din);
      end
    end
    if (ret_pred_valid) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pred_unexpected: got valid hit=%0b addr=0x%0h at cycle %0d, expected none",
                 ret_pred_hit, ret_pred_addr, cyc);
      end else begin
        pe = pq.pop_front();
        chk("pred_cycle", 32'(cyc), 32'(pe.cyc));
        chk("pred_hit", {31'd0, ret_pred_hit}, {31'd0, pe.hit});
        chk("pred_addr", ret_pred_addr, pe.addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit c, input bit r, input bit b, input logic [31:0] a,
                    input bit e_push, input bit e_pop, input bit e_br,
                    input bit e_pred, input bit e_hit, input logic [31:0] e_addr);
    strobe_t s;
    pred_t   p;
    chk("f_ready_op", {31'd0, f_ready}, 32'd1);
    f_valid = 1'b1; f_call = c; f_ret = r; f_branch = b; f_ret_addr = a;
    if (e_push || e_pop || e_br) begin
      s.cyc = cyc + 1; s.push = e_push; s.pop = e_pop; s.br = e_br;
      s.cv = 1'b0; s.ci = 1'b0; s.din = a;
      sq.push_back(s);
    end
    if (e_pred) begin
      p.cyc = cyc + 2; p.hit = e_hit; p.addr = e_addr;
      pq.push_back(p);
    end
    step();
    f_valid = 1'b0; f_call = 1'b0; f_ret = 1'b0; f_branch = 1'b0; f_ret_addr = '0;
  endtask

  task automatic res(input bit mp);
    strobe_t s;
    res_valid = 1'b1; res_mispredict = mp;
    #1;
    chk("f_ready_res", {31'd0, f_ready}, 32'd0);
    chk("f_br_ready_spec", {31'd0, f_br_ready}, 32'd0);
    s.cyc = cyc + 1; s.push = 1'b0; s.pop = 1'b0; s.br = 1'b0;
    s.cv = !mp; s.ci = mp; s.din = '0;
    sq.push_back(s);
    @(posedge clk);
    #1;
    res_valid = 1'b0; res_mispredict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    f_valid = 0; f_call = 0; f_ret = 0; f_branch = 0; f_ret_addr = '0;
    res_valid = 0; res_mispredict = 0;
    g_valid = 0; g_call = 0; g_ret = 0; g_branch = 0; g_ret_addr = '0;
    g_res_valid = 0; g_res_mp = 0;

    #2;
    chk("reset_flags", {22'd0, f_ready, f_br_ready, ras_push, ras_pop, ras_branch,
        ras_close_valid, ras_close_invalid, ret_pred_valid, ret_pred_hit, overflow}, 32'd0);
    chk("reset_pred_addr", ret_pred_addr, 32'd0);
    @(negedge clk);
    chk("reset_f_ready_held", {31'd0, f_ready}, 32'd0);
    #2;
    rst = 1'b0; rst2 = 1'b0;
    step();
    chk("post_reset_f_ready", {31'd0, f_ready}, 32'd1);
    chk("post_reset_f_br_ready", {31'd0, f_br_ready}, 32'd1);
    chk("post_reset_count", 32'(dut.u_occ.count_q), 32'd0);

    // calls then returns, back to back
    op(1, 0, 0, 32'h100, 1, 0, 0, 0, 0, 0);
    op(1, 0, 0, 32'h200, 1, 0, 0, 0, 0, 0);
    op(0, 1, 0, 32'h0,   0, 1, 0, 1, 1, 32'h200);
    op(0, 1, 0, 32'h0,   0, 1, 0, 1, 1, 32'h100);
    chk("count_after_pairs", 32'(dut.u_occ.count_q), 32'd0);

    // empty-stack return: no pop, miss prediction
    op(0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    step(); step();

    // call+ret in one op
    op(1, 1, 0, 32'h50, 1, 0, 0, 1, 0, 32'h0);
    op(1, 1, 0, 32'h60, 1, 1, 0, 1, 1, 32'h50);
    chk("count_callret", 32'(dut.u_occ.count_q), 32'd1);
    op(0, 1, 0, 32'h0, 0, 1, 0, 1, 1, 32'h60);
    step(); step();

    // mispredicted window
    op(1, 0, 0, 32'h10, 1, 0, 0, 0, 0, 0);
    op(0, 0, 1, 32'h0,  0, 0, 1, 0, 0, 0);
    chk("f_br_ready_in_spec", {31'd0, f_br_ready}, 32'd0);
    op(1, 0, 0, 32'h20, 1, 0, 0, 0, 0, 0);
    res(1);
    chk("f_br_ready_resolve", {31'd0, f_br_ready}, 32'd1);
    step();
    chk("count_restored", 32'(dut.u_occ.count_q), 32'd1);
    op(0, 1, 0, 32'h0, 0, 1, 0, 1, 1, 32'h10);
    step(); step();

    // correctly predicted window
    op(1, 0, 0, 32'h10, 1, 0, 0, 0, 0, 0);
    op(0, 0, 1, 32'h0,  0, 0, 1, 0, 0, 0);
    op(1, 0, 0, 32'h20, 1, 0, 0, 0, 0, 0);
    res(0);
    step();
    chk("count_kept", 32'(dut.u_occ.count_q), 32'd2);
    op(0, 1, 0, 32'h0, 0, 1, 0, 1, 1, 32'h20);
    op(0, 1, 0, 32'h0, 0, 1, 0, 1, 1, 32'h10);
    step(); step();

    // ret in flight killed by mispredict, then ret+branch accepted in RESOLVE
    op(1, 0, 0, 32'h30, 1, 0, 0, 0, 0, 0);
    op(0, 0, 1, 32'h0,  0, 0, 1, 0, 0, 0);
    op(1, 0, 0, 32'h40, 1, 0, 0, 0, 0, 0);
    op(0, 1, 0, 32'h0,  0, 1, 0, 0, 0, 0);
    res(1);
    chk("pred_killed", {31'd0, ret_pred_valid}, 32'd0);
    op(0, 1, 1, 32'h0, 0, 1, 1, 1, 1, 32'h30);
    chk("f_br_ready_reopened", {31'd0, f_br_ready}, 32'd0);
    res(0);
    step();
    chk("count_after_reopen", 32'(dut.u_occ.count_q), 32'd0);
    chk("overflow_main", {31'd0, overflow}, 32'd0);

    // DEPTH=4 instance: saturation then reset in the middle of a window
    for (int i = 0; i < 5; i++) begin
      g_valid = 1'b1; g_call = 1'b1; g_ret_addr = 32'(i + 1);
      step();
      if (i == 3) begin
        chk("small_count_full", 32'(dut2.u_occ.count_q), 32'd4);
        chk("small_ovf_clear", {31'd0, g_ovf}, 32'd0);
      end
    end
    g_call = 1'b0;
    chk("small_count_sat", 32'(dut2.u_occ.count_q), 32'd4);
    chk("small_ovf_set", {31'd0, g_ovf}, 32'd1);
    g_branch = 1'b1;
    step();
    g_branch = 1'b0;
    chk("small_spec", {31'd0, g_br_ready}, 32'd0);
    g_ret = 1'b1;
    step();
    g_ret = 1'b0; g_valid = 1'b0;
    chk("small_pop_strobe", {31'd0, g_pop}, 32'd1);
    rst2 = 1'b1;
    #1;
    chk("small_reset_flags", {22'd0, g_ready, g_br_ready, g_push, g_pop, g_br_o,
        g_cv, g_ci, g_pred_valid, g_pred_hit, g_ovf}, 32'd0);
    chk("small_reset_din", g_din, 32'd0);
    chk("small_reset_pred_addr", g_pred_addr, 32'd0);
    chk("small_reset_count", 32'(dut2.u_occ.count_q), 32'd0);
    chk("small_reset_ckpt", 32'(dut2.u_occ.ckpt_q), 32'd0);
    chk("small_reset_state", 32'(dut2.state_q), 32'd0);
    step();
    rst2 = 1'b0;
    step();
    chk("small_idle_br_ready", {31'd0, g_br_ready}, 32'd1);
    chk("small_idle_ready", {31'd0, g_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("small_no_stale_out", {29'd0, g_pred_valid, g_cv, g_ci}, 32'd0);
      step();
    end

    step(); step();
    chk("strobe_queue_drained", 32'(sq.size()), 32'd0);
    chk("pred_queue_drained", 32'(pq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
